// File: rtl/cpu_pkg.sv
// Shared CPU types: instruction word layout, fetch FSM states and
// the opcodes the fetch stage executes itself.
package cpu_pkg;

   localparam logic [3:0] OP_JMP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] lit;
   } instr_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_HALT
   } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Program-load and issue bundle between the fetch stage and its
// controller/consumer.
interface inst_fetch_if #(
   parameter int ADDR_W = 4
) ();

   logic              start;
   logic              hold;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [19:0]       prog_data;
   logic [3:0]        inst;
   logic [15:0]       f;
   logic              valid;
   logic [ADDR_W-1:0] pc;
   logic              halted;

   modport master (
      output start, hold, prog_we, prog_addr, prog_data,
      input  inst, f, valid, pc, halted
   );

   modport slave (
      input  start, hold, prog_we, prog_addr, prog_data,
      output inst, f, valid, pc, halted
   );

endinterface

// File: rtl/inst_fetch_prog_mem.sv
// Program RAM: one write port, one synchronous read port whose
// registered output doubles as the instruction register.
module prog_mem
   import cpu_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  instr_t            i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output instr_t            o_rdata
);

   instr_t r_mem [DEPTH];
   instr_t r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_fetch.sv
// Fetch/issue stage: PC sequencer with local JMP/HALT and registered
// opcode/literal issue toward the ALU.
module inst_fetch
   import cpu_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   inst_fetch_if.slave bus
);

   fetch_state_t      r_state, w_state;
   logic [ADDR_W-1:0] r_pc, w_pc;
   logic [3:0]        r_inst, w_inst;
   logic [15:0]       r_f, w_f;
   logic              r_valid, w_valid;
   logic              r_halted, w_halted;
   logic              w_idle;
   logic              w_we;
   logic              w_re;
   instr_t            w_ir;

   assign w_idle = (r_state == S_IDLE) || (r_state == S_HALT);
   assign w_we   = bus.prog_we && w_idle;
   assign w_re   = (r_state == S_FETCH);

   prog_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (bus.prog_addr),
      .i_wdata (instr_t'(bus.prog_data)),
      .i_re    (w_re),
      .i_raddr (r_pc),
      .o_rdata (w_ir)
   );

   always_comb begin
      w_state  = r_state;
      w_pc     = r_pc;
      w_inst   = r_inst;
      w_f      = r_f;
      w_valid  = 1'b0;
      w_halted = r_halted;
      unique case (r_state)
         S_IDLE, S_HALT: begin
            if (bus.start) begin
               w_pc     = '0;
               w_halted = 1'b0;
               w_state  = S_FETCH;
            end
         end
         S_FETCH: w_state = S_ISSUE;
         S_ISSUE: begin
            unique case (1'b1)
               (w_ir.op == OP_JMP): begin
                  w_pc    = w_ir.lit[ADDR_W-1:0];
                  w_state = S_FETCH;
               end
               (w_ir.op == OP_HALT): begin
                  w_halted = 1'b1;
                  w_state  = S_HALT;
               end
               default: begin
                  // Reloading the same word keeps outputs frozen under hold.
                  w_inst  = w_ir.op;
                  w_f     = w_ir.lit;
                  w_valid = 1'b1;
                  if (!bus.hold) begin
                     w_pc    = r_pc + ADDR_W'(1);
                     w_state = S_FETCH;
                  end
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_pc     <= '0;
         r_inst   <= '0;
         r_f      <= '0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_pc     <= w_pc;
         r_inst   <= w_inst;
         r_f      <= w_f;
         r_valid  <= w_valid;
         r_halted <= w_halted;
      end
   end

   assign bus.inst   = r_inst;
   assign bus.f      = r_f;
   assign bus.valid  = r_valid;
   assign bus.pc     = r_pc;
   assign bus.halted = r_halted;

endmodule
